// File: rtl/wb_stage_param.sv
// ---------------------------------------------------------------------------
// wb_stage_param -- write-back stage of the 5-stage RISC-V pipeline.
//
// Holds the MEM/WB pipeline register (valid/stall/flush controlled), aligns
// and extends load data, selects the write-back result from ALU / load /
// PC+4 / CSR, and optionally keeps a retired-instruction counter.
//
// Optional feature macro: WB_INSTRET_EN
//   defined   : instret_w is a CNT_W-bit counter of retired instructions
//   undefined : no counter flops, instret_w is tied to 0
//
// Ports
//   clk           rising-edge clock
//   srst          asynchronous active-low reset
//   stall_i       hold MEM/WB contents
//   flush_i       load a bubble into MEM/WB (wins over stall_i)
//   valid_m       M-stage instruction valid
//   reg_write_m   M-stage register-file write enable
//   result_src_m  result select: 00 ALU, 01 load, 10 PC+4, 11 CSR
//   funct3_m      load type
//   rd_m          destination register
//   alu_result_m  ALU result / load address
//   read_data_m   raw data-memory word
//   pc_plus4_m    PC+4
//   csr_rdata_m   CSR read data
//   valid_w       W-stage valid
//   reg_write_w   qualified register-file write enable (never for x0)
//   rd_w          register-file write address
//   result_w      register-file write data
//   instret_w     retired-instruction count
// ---------------------------------------------------------------------------
module wb_stage_param #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned RF_ADDR_W = 5,
  parameter int unsigned CNT_W     = 64
) (
  input  logic                 clk,
  input  logic                 srst,
  input  logic                 stall_i,
  input  logic                 flush_i,
  input  logic                 valid_m,
  input  logic                 reg_write_m,
  input  logic [1:0]           result_src_m,
  input  logic [2:0]           funct3_m,
  input  logic [RF_ADDR_W-1:0] rd_m,
  input  logic [XLEN-1:0]      alu_result_m,
  input  logic [XLEN-1:0]      read_data_m,
  input  logic [XLEN-1:0]      pc_plus4_m,
  input  logic [XLEN-1:0]      csr_rdata_m,
  output logic                 valid_w,
  output logic                 reg_write_w,
  output logic [RF_ADDR_W-1:0] rd_w,
  output logic [XLEN-1:0]      result_w,
  output logic [CNT_W-1:0]     instret_w
);

  // MEM/WB pipeline register
  logic                 valid_q,     valid_d;
  logic                 reg_write_q, reg_write_d;
  logic [1:0]           src_q,       src_d;
  logic [2:0]           funct3_q,    funct3_d;
  logic [RF_ADDR_W-1:0] rd_q,        rd_d;
  logic [XLEN-1:0]      alu_q,       alu_d;
  logic [XLEN-1:0]      rdata_q,     rdata_d;
  logic [XLEN-1:0]      pc4_q,       pc4_d;
  logic [XLEN-1:0]      csr_q,       csr_d;

  always_comb begin
    valid_d     = valid_q;
    reg_write_d = reg_write_q;
    src_d       = src_q;
    funct3_d    = funct3_q;
    rd_d        = rd_q;
    alu_d       = alu_q;
    rdata_d     = rdata_q;
    pc4_d       = pc4_q;
    csr_d       = csr_q;
    if (flush_i) begin
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
      src_d       = '0;
      funct3_d    = '0;
      rd_d        = '0;
      alu_d       = '0;
      rdata_d     = '0;
      pc4_d       = '0;
      csr_d       = '0;
    end else if (!stall_i) begin
      valid_d     = valid_m;
      reg_write_d = reg_write_m;
      src_d       = result_src_m;
      funct3_d    = funct3_m;
      rd_d        = rd_m;
      alu_d       = alu_result_m;
      rdata_d     = read_data_m;
      pc4_d       = pc_plus4_m;
      csr_d       = csr_rdata_m;
    end
  end

  always_ff @(posedge clk or negedge srst) begin
    if (!srst) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      src_q       <= '0;
      funct3_q    <= '0;
      rd_q        <= '0;
      alu_q       <= '0;
      rdata_q     <= '0;
      pc4_q       <= '0;
      csr_q       <= '0;
    end else begin
      valid_q     <= valid_d;
      reg_write_q <= reg_write_d;
      src_q       <= src_d;
      funct3_q    <= funct3_d;
      rd_q        <= rd_d;
      alu_q       <= alu_d;
      rdata_q     <= rdata_d;
      pc4_q       <= pc4_d;
      csr_q       <= csr_d;
    end
  end

  // Load alignment: only the low 32 bits of the memory word are meaningful.
  // Halfword select ignores addr[0]; memory never returns misaligned data.
  logic [7:0]      load_byte;
  logic [15:0]     load_half;
  logic [XLEN-1:0] load_ext;

  always_comb begin
    case (alu_q[1:0])
      2'd0:    load_byte = rdata_q[7:0];
      2'd1:    load_byte = rdata_q[15:8];
      2'd2:    load_byte = rdata_q[23:16];
      default: load_byte = rdata_q[31:24];
    endcase
    load_half = alu_q[1] ? rdata_q[31:16] : rdata_q[15:0];
  end

  always_comb begin
    case (funct3_q)
      3'b000:  load_ext = XLEN'($signed(load_byte));
      3'b100:  load_ext = XLEN'(load_byte);
      3'b001:  load_ext = XLEN'($signed(load_half));
      3'b101:  load_ext = XLEN'(load_half);
      3'b010:  load_ext = XLEN'($signed(rdata_q[31:0]));
      default: load_ext = rdata_q;
    endcase
  end

  // Result mux follows the registered select even for bubbles;
  // consumers qualify with reg_write_w.
  always_comb begin
    case (src_q)
      2'b00:   result_w = alu_q;
      2'b01:   result_w = load_ext;
      2'b10:   result_w = pc4_q;
      default: result_w = csr_q;
    endcase
  end

  assign valid_w     = valid_q;
  assign rd_w        = rd_q;
  assign reg_write_w = valid_q & reg_write_q & (rd_q != '0);

`ifdef WB_INSTRET_EN
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             retire;

  // Counts on the edge where a valid instruction enters MEM/WB; wraps silently.
  assign retire = ~flush_i & ~stall_i & valid_m;

  always_comb begin
    instret_d = instret_q;
    if (retire) instret_d = instret_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge srst) begin
    if (!srst) instret_q <= '0;
    else       instret_q <= instret_d;
  end

  assign instret_w = instret_q;
`else
  assign instret_w = '0;
`endif

endmodule

// File: tb/tb_wb_stage_param.sv
module tb_wb_stage_param;

  logic        clk = 1'b0;
  logic        srst;
  logic        stall_i, flush_i;
  logic        valid_m, reg_write_m;
  logic [1:0]  result_src_m;
  logic [2:0]  funct3_m;
  logic [4:0]  rd_m;
  logic [31:0] alu_result_m, read_data_m, pc_plus4_m, csr_rdata_m;

  logic        valid_w, reg_write_w;
  logic [4:0]  rd_w;
  logic [31:0] result_w;
  logic [63:0] instret_w;

  logic        wv_valid, wv_rw;
  logic [4:0]  wv_rd;
  logic [31:0] wv_result;
  logic [3:0]  wv_instret;

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] exp_cnt = '0;

  always #5 clk = ~clk;

  wb_stage_param u_dut (
    .clk(clk), .srst(srst), .stall_i(stall_i), .flush_i(flush_i),
    .valid_m(valid_m), .reg_write_m(reg_write_m), .result_src_m(result_src_m),
    .funct3_m(funct3_m), .rd_m(rd_m), .alu_result_m(alu_result_m),
    .read_data_m(read_data_m), .pc_plus4_m(pc_plus4_m), .csr_rdata_m(csr_rdata_m),
    .valid_w(valid_w), .reg_write_w(reg_write_w), .rd_w(rd_w),
    .result_w(result_w), .instret_w(instret_w)
  );

  wb_stage_param #(.CNT_W(4)) u_wrap (
    .clk(clk), .srst(srst), .stall_i(stall_i), .flush_i(flush_i),
    .valid_m(valid_m), .reg_write_m(reg_write_m), .result_src_m(result_src_m),
    .funct3_m(funct3_m), .rd_m(rd_m), .alu_result_m(alu_result_m),
    .read_data_m(read_data_m), .pc_plus4_m(pc_plus4_m), .csr_rdata_m(csr_rdata_m),
    .valid_w(wv_valid), .reg_write_w(wv_rw), .rd_w(wv_rd),
    .result_w(wv_result), .instret_w(wv_instret)
  );

  typedef struct {
    logic        v;
    logic        rw;
    logic [1:0]  src;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] pc4;
    logic [31:0] csr;
    logic        e_valid;
    logic        e_rw;
    logic [31:0] e_res;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] exp_instret();
`ifdef WB_INSTRET_EN
    return exp_cnt;
`else
    return 64'd0;
`endif
  endfunction

  task automatic set_m(input logic v, input logic rw, input logic [1:0] src,
                       input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] rdata,
                       input logic [31:0] pc4, input logic [31:0] csr);
    valid_m = v; reg_write_m = rw; result_src_m = src; funct3_m = f3; rd_m = rd;
    alu_result_m = alu; read_data_m = rdata; pc_plus4_m = pc4; csr_rdata_m = csr;
  endtask

  // One clock edge plus the reference counter update; samples land #1 later.
  task automatic step();
    @(posedge clk);
    if (srst && !flush_i && !stall_i && valid_m) exp_cnt++;
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " valid_w"},     {63'd0, valid_w},     64'd0);
    chk({tag, " reg_write_w"}, {63'd0, reg_write_w}, 64'd0);
    chk({tag, " rd_w"},        {59'd0, rd_w},        64'd0);
    chk({tag, " result_w"},    {32'd0, result_w},    64'd0);
    chk({tag, " instret_w"},   instret_w,            64'd0);
  endtask

  task automatic chk_out(input string tag, input logic v, input logic rw,
                         input logic [4:0] rd, input logic [31:0] res);
    chk({tag, " valid_w"},     {63'd0, valid_w},     {63'd0, v});
    chk({tag, " reg_write_w"}, {63'd0, reg_write_w}, {63'd0, rw});
    chk({tag, " rd_w"},        {59'd0, rd_w},        {59'd0, rd});
    chk({tag, " result_w"},    {32'd0, result_w},    {32'd0, res});
    chk({tag, " instret_w"},   instret_w,            exp_instret());
  endtask

  initial begin
    //             v   rw  src    f3      rd     alu            rdata          pc4            csr            ev  erw  eres
    vecs[0]  = '{1'b1,1'b1,2'b01,3'b000,5'd1, 32'h0000_1003,32'h80FF_1234,32'h0,        32'h0,        1'b1,1'b1,32'hFFFF_FF80};
    vecs[1]  = '{1'b1,1'b1,2'b01,3'b100,5'd2, 32'h0000_1003,32'h80FF_1234,32'h0,        32'h0,        1'b1,1'b1,32'h0000_0080};
    vecs[2]  = '{1'b1,1'b1,2'b01,3'b001,5'd3, 32'h0000_1002,32'h8001_7FFF,32'h0,        32'h0,        1'b1,1'b1,32'hFFFF_8001};
    vecs[3]  = '{1'b1,1'b1,2'b01,3'b101,5'd4, 32'h0000_1000,32'h8001_7FFF,32'h0,        32'h0,        1'b1,1'b1,32'h0000_7FFF};
    vecs[4]  = '{1'b1,1'b1,2'b01,3'b000,5'd5, 32'h0000_1001,32'h80FF_1234,32'h0,        32'h0,        1'b1,1'b1,32'h0000_0012};
    vecs[5]  = '{1'b1,1'b1,2'b01,3'b000,5'd6, 32'h0000_1002,32'h80FF_1234,32'h0,        32'h0,        1'b1,1'b1,32'hFFFF_FFFF};
    vecs[6]  = '{1'b1,1'b1,2'b01,3'b100,5'd7, 32'h0000_1000,32'h80FF_1234,32'h0,        32'h0,        1'b1,1'b1,32'h0000_0034};
    vecs[7]  = '{1'b1,1'b1,2'b01,3'b001,5'd8, 32'h0000_1003,32'h1234_5678,32'h0,        32'h0,        1'b1,1'b1,32'h0000_1234};
    vecs[8]  = '{1'b1,1'b1,2'b01,3'b101,5'd9, 32'h0000_1002,32'hFFFF_0000,32'h0,        32'h0,        1'b1,1'b1,32'h0000_FFFF};
    vecs[9]  = '{1'b1,1'b1,2'b01,3'b001,5'd10,32'h0000_1001,32'h0000_9ABC,32'h0,        32'h0,        1'b1,1'b1,32'hFFFF_9ABC};
    vecs[10] = '{1'b1,1'b1,2'b01,3'b010,5'd11,32'h0000_1000,32'hDEAD_BEEF,32'h0,        32'h0,        1'b1,1'b1,32'hDEAD_BEEF};
    vecs[11] = '{1'b1,1'b1,2'b01,3'b011,5'd12,32'h0000_1001,32'hCAFE_F00D,32'h0,        32'h0,        1'b1,1'b1,32'hCAFE_F00D};
    vecs[12] = '{1'b1,1'b1,2'b00,3'b000,5'd13,32'h1234_5683,32'h80FF_1234,32'h0,        32'h0,        1'b1,1'b1,32'h1234_5683};
    vecs[13] = '{1'b1,1'b1,2'b10,3'b000,5'd14,32'h0000_0003,32'h80FF_1234,32'h0000_4008,32'h0,        1'b1,1'b1,32'h0000_4008};
    vecs[14] = '{1'b1,1'b1,2'b11,3'b000,5'd15,32'h0000_0003,32'h80FF_1234,32'h0000_4008,32'hA5A5_0F0F,1'b1,1'b1,32'hA5A5_0F0F};
    vecs[15] = '{1'b1,1'b1,2'b00,3'b000,5'd0, 32'h0000_0077,32'h0,        32'h0,        32'h0,        1'b1,1'b0,32'h0000_0077};
    vecs[16] = '{1'b0,1'b1,2'b10,3'b000,5'd17,32'h0,        32'h0,        32'h0000_1234,32'h0,        1'b0,1'b0,32'h0000_1234};
    vecs[17] = '{1'b1,1'b0,2'b00,3'b000,5'd18,32'h0000_0055,32'h0,        32'h0,        32'h0,        1'b1,1'b0,32'h0000_0055};

    srst = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    set_m(1'b0, 1'b0, 2'b00, 3'b000, 5'd0, '0, '0, '0, '0);
    #2;
    chk_zero("reset");
    @(negedge clk); srst = 1'b1;

    // Table-driven single-cycle vectors.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      set_m(vecs[i].v, vecs[i].rw, vecs[i].src, vecs[i].f3, vecs[i].rd,
            vecs[i].alu, vecs[i].rdata, vecs[i].pc4, vecs[i].csr);
      step();
      chk_out($sformatf("v%0d", i), vecs[i].e_valid, vecs[i].e_rw, vecs[i].rd, vecs[i].e_res);
    end

    // Asynchronous reset asserted mid-cycle with valid traffic.
    @(negedge clk);
    set_m(1'b1, 1'b1, 2'b00, 3'b000, 5'd21, 32'h0000_0BAD, '0, '0, '0);
    step();
    chk_out("pre_areset", 1'b1, 1'b1, 5'd21, 32'h0000_0BAD);
    #2 srst = 1'b0; exp_cnt = '0;
    #1 chk_zero("areset");
    @(negedge clk); srst = 1'b1;

    // Stall holds, flush beats stall.
    @(negedge clk);
    set_m(1'b1, 1'b1, 2'b00, 3'b000, 5'd5, 32'h0000_002A, '0, '0, '0);
    step();
    chk_out("add", 1'b1, 1'b1, 5'd5, 32'h0000_002A);
    @(negedge clk);
    set_m(1'b1, 1'b1, 2'b11, 3'b000, 5'd9, 32'h0000_0099, '0, '0, 32'h0000_0777);
    stall_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk_out($sformatf("stall%0d", c), 1'b1, 1'b1, 5'd5, 32'h0000_002A);
    end
    @(negedge clk); flush_i = 1'b1;
    step();
    chk("flush+stall valid_w",     {63'd0, valid_w},     64'd0);
    chk("flush+stall reg_write_w", {63'd0, reg_write_w}, 64'd0);
    chk("flush+stall instret_w",   instret_w,            exp_instret());
    @(negedge clk); flush_i = 1'b0; stall_i = 1'b0;
    step();
    chk_out("post_flush", 1'b1, 1'b1, 5'd9, 32'h0000_0777);
    @(negedge clk); flush_i = 1'b1;
    step();
    chk("flush valid_w",     {63'd0, valid_w},     64'd0);
    chk("flush reg_write_w", {63'd0, reg_write_w}, 64'd0);
    chk("flush instret_w",   instret_w,            exp_instret());
    @(negedge clk); flush_i = 1'b0;

    // Reset during a stall, then the first edge loads normally.
    set_m(1'b1, 1'b1, 2'b00, 3'b000, 5'd3, 32'h0000_0033, '0, '0, '0);
    step();
    @(negedge clk); stall_i = 1'b1;
    step();
    chk_out("stall_hold", 1'b1, 1'b1, 5'd3, 32'h0000_0033);
    #2 srst = 1'b0; exp_cnt = '0;
    #1 chk_zero("reset_in_stall");
    @(negedge clk);
    srst = 1'b1; stall_i = 1'b0;
    set_m(1'b1, 1'b1, 2'b00, 3'b000, 5'd4, 32'h0000_0044, '0, '0, '0);
    step();
    chk_out("first_after_reset", 1'b1, 1'b1, 5'd4, 32'h0000_0044);

    // 4-bit counter wrap on the CNT_W=4 instance.
    @(negedge clk); srst = 1'b0; exp_cnt = '0;
    #1 chk("wrap reset", {60'd0, wv_instret}, 64'd0);
    @(negedge clk); srst = 1'b1;
    set_m(1'b1, 1'b1, 2'b00, 3'b000, 5'd1, 32'h1, '0, '0, '0);
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      alu_result_m = 32'(k);
      step();
`ifdef WB_INSTRET_EN
      if (k == 15) chk("wrap15", {60'd0, wv_instret}, 64'd15);
      if (k == 16) chk("wrap16", {60'd0, wv_instret}, 64'd0);
      if (k == 17) chk("wrap17", {60'd0, wv_instret}, 64'd1);
`else
      if (k >= 15) chk($sformatf("nocnt%0d", k), {60'd0, wv_instret}, 64'd0);
`endif
    end
    chk("wide instret after 17", instret_w, exp_instret());
    chk("wrap result_w", {32'd0, wv_result}, 64'd17);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
